// File: rtl/qam_frame_sequencer_if.sv
// rtl/qam_frame_sequencer_if.sv - command, byte and symbol handshake bundle for the QAM frame sequencer
interface qam_frame_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sym_idx;
  logic             sym_valid;
  logic             sym_ready;
  logic             sym_is_preamble;
  logic             busy;
  logic             done;

  modport master (
    output start, frame_len, in_data, in_valid, sym_ready,
    input  in_ready, sym_idx, sym_valid, sym_is_preamble, busy, done
  );

  modport slave (
    input  start, frame_len, in_data, in_valid, sym_ready,
    output in_ready, sym_idx, sym_valid, sym_is_preamble, busy, done
  );
endinterface

// File: rtl/qam_frame_sequencer.sv
// rtl/qam_frame_sequencer.sv - frame controller: preamble, byte-to-symbol split, guard gap
module qam_frame_sequencer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GAP_LEN      = 4,
  parameter int LEN_W        = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  qam_frame_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);

  state_t           state;
  logic [7:0]       pre_cnt;
  logic [7:0]       gap_cnt;
  logic [LEN_W-1:0] bytes_left;
  logic [7:0]       byte_buf;
  logic             buf_full;
  logic [1:0]       k;
  logic [1:0]       sym_idx;
  logic             sym_valid;
  logic             sym_is_preamble;
  logic             done;
  logic             slot_free;
  logic             in_ready;
  logic             in_fire;

  assign slot_free = !sym_valid || bus.sym_ready;
  assign in_ready  = (state == PAYLOAD) && !buf_full && (bytes_left != '0);
  assign in_fire   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pre_cnt         <= '0;
      gap_cnt         <= '0;
      bytes_left      <= '0;
      byte_buf        <= '0;
      buf_full        <= 1'b0;
      k               <= '0;
      sym_idx         <= '0;
      sym_valid       <= 1'b0;
      sym_is_preamble <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      // A free slot with nothing new to load becomes a bubble; loads below override this.
      if (slot_free) sym_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            // The first preamble symbol is loaded on the accepting edge to meet one-cycle latency.
            bytes_left      <= bus.frame_len;
            buf_full        <= 1'b0;
            k               <= '0;
            gap_cnt         <= '0;
            pre_cnt         <= 8'd1;
            sym_idx         <= 2'd0;
            sym_valid       <= 1'b1;
            sym_is_preamble <= 1'b1;
            state           <= (PRE_LAST == 8'd0) ? PAYLOAD : PREAMBLE;
          end
        end

        PREAMBLE: begin
          if (slot_free) begin
            sym_idx         <= {pre_cnt[0], 1'b0};
            sym_valid       <= 1'b1;
            sym_is_preamble <= 1'b1;
            pre_cnt         <= pre_cnt + 8'd1;
            if (pre_cnt == PRE_LAST) state <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (in_fire) begin
            byte_buf   <= bus.in_data;
            buf_full   <= 1'b1;
            bytes_left <= bytes_left - 1'b1;
            k          <= '0;
          end
          if (buf_full && slot_free) begin
            sym_idx         <= byte_buf[{k, 1'b0} +: 2];
            sym_valid       <= 1'b1;
            sym_is_preamble <= 1'b0;
            k               <= k + 2'd1;
            if (k == 2'd3) buf_full <= 1'b0;
          end else if ((bytes_left == '0) && !buf_full && slot_free) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.sym_idx         = sym_idx;
  assign bus.sym_valid       = sym_valid;
  assign bus.sym_is_preamble = sym_is_preamble;
  assign bus.busy            = (state != IDLE);
  assign bus.done            = done;
endmodule

// File: tb/tb_qam_frame_sequencer.sv
// tb/tb_qam_frame_sequencer.sv - directed self-checking bench for qam_frame_sequencer
module tb_qam_frame_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  qam_frame_sequencer_if #(.LEN_W(8)) bus ();

  qam_frame_sequencer #(.PREAMBLE_LEN(8), .GAP_LEN(4), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] got[$];
  int hs_cyc[$];
  int acc_cyc[$];
  int done_cyc, unstable, in_ready_cnt, bubbles, tstart;
  logic busy_at_done;
  logic [7:0] tx_bytes[4];
  int nbytes;
  logic [2:0] exp_seq[16];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives one frame and records every symbol handshake; the calling test does the comparisons.
  task automatic run_frame(input logic do_start, input logic [7:0] len, input int rmode,
                           input int starve_after, input int starve_len, input logic noise);
    int bi, ph, starve_left, budget, total;
    logic stalled;
    logic [2:0] held;
    bi = 0; ph = 0; starve_left = starve_len; budget = 0; stalled = 1'b0; held = '0;
    total = 8 + 4 * nbytes;
    got.delete(); hs_cyc.delete(); acc_cyc.delete();
    done_cyc = -1; unstable = 0; in_ready_cnt = 0; bubbles = 0; busy_at_done = 1'b1;
    if (do_start) begin
      bus.start = 1'b1; bus.frame_len = len; tstart = cyc;
      tick();
      bus.start = 1'b0;
    end
    if (noise) bus.frame_len = 8'd5;
    while (done_cyc < 0) begin
      if (bus.done) begin
        done_cyc = cyc; busy_at_done = bus.busy;
        break;
      end
      if (budget == 400) begin
        checks++; errors++;
        $display("FAIL frame_timeout: no done after %0d cycles, required done within 400", budget);
        break;
      end
      if (stalled && (!bus.sym_valid || {bus.sym_is_preamble, bus.sym_idx} != held)) unstable++;
      if (bus.in_ready) in_ready_cnt++;
      if (bus.busy && !bus.sym_valid && got.size() >= 8 && got.size() < total) bubbles++;
      bus.sym_ready = (rmode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
      ph++;
      bus.start = noise && ((ph == 3) || (got.size() == total && bus.busy && !bus.sym_valid));
      if (starve_left > 0 && bi == starve_after) begin
        bus.in_valid = 1'b0; starve_left--;
      end else begin
        bus.in_valid = (bi < nbytes);
      end
      bus.in_data = (bi < nbytes) ? tx_bytes[bi] : 8'h00;
      if (bus.sym_valid && bus.sym_ready) begin
        got.push_back({bus.sym_is_preamble, bus.sym_idx});
        hs_cyc.push_back(cyc);
      end
      stalled = bus.sym_valid && !bus.sym_ready;
      held = {bus.sym_is_preamble, bus.sym_idx};
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc.push_back(cyc);
        bi++;
      end
      tick();
      budget++;
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.sym_ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.sym_idx, bus.sym_valid, bus.sym_is_preamble, bus.busy, bus.done, bus.in_ready} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {bus.sym_idx, bus.sym_valid, bus.sym_is_preamble, bus.busy, bus.done, bus.in_ready});
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.sym_valid, bus.busy, bus.done} !== 3'd0) begin
      errors++;
      $display("FAIL idle_after_release: got %b required 000", {bus.sym_valid, bus.busy, bus.done});
    end
  endtask

  task automatic test_basic();
    tx_bytes[0] = 8'hE4; tx_bytes[1] = 8'h1B; nbytes = 2;
    run_frame(1'b1, 8'd2, 0, 0, 0, 1'b0);
    checks++;
    if (got.size() != 16) begin
      errors++; $display("FAIL basic_count: got %0d symbols required 16", got.size());
    end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_seq[i]) begin
        errors++; $display("FAIL basic_sym[%0d]: got %b required %b", i, got[i], exp_seq[i]);
      end
    end
    if (got.size() == 16) begin
      checks++;
      if (hs_cyc[0] != tstart + 1 || hs_cyc[7] != tstart + 8) begin
        errors++;
        $display("FAIL basic_preamble_timing: got first %0d last %0d required %0d %0d",
                 hs_cyc[0], hs_cyc[7], tstart + 1, tstart + 8);
      end
      checks++;
      if (hs_cyc[8] != tstart + 10 || hs_cyc[12] - hs_cyc[8] != 5) begin
        errors++;
        $display("FAIL basic_payload_rate: got first %0d spacing %0d required %0d 5",
                 hs_cyc[8], hs_cyc[12] - hs_cyc[8], tstart + 10);
      end
      checks++;
      if (done_cyc != hs_cyc[15] + 5) begin
        errors++; $display("FAIL basic_done_time: got %0d required %0d", done_cyc, hs_cyc[15] + 5);
      end
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++; $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got done %b busy %b required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_stall();
    tx_bytes[0] = 8'hE4; tx_bytes[1] = 8'h1B; nbytes = 2;
    run_frame(1'b1, 8'd2, 1, 0, 0, 1'b0);
    checks++;
    if (got.size() != 16) begin
      errors++; $display("FAIL stall_count: got %0d symbols required 16", got.size());
    end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_seq[i]) begin
        errors++; $display("FAIL stall_sym[%0d]: got %b required %b", i, got[i], exp_seq[i]);
      end
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL stall_stability: got %0d changes during stall required 0", unstable);
    end
    if (got.size() == 16) begin
      checks++;
      if (done_cyc != hs_cyc[15] + 5) begin
        errors++; $display("FAIL stall_done_time: got %0d required %0d", done_cyc, hs_cyc[15] + 5);
      end
    end
    tick();
  endtask

  task automatic test_zero_len();
    nbytes = 0;
    run_frame(1'b1, 8'd0, 0, 0, 0, 1'b0);
    checks++;
    if (got.size() != 8) begin
      errors++; $display("FAIL zero_count: got %0d symbols required 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_seq[i]) begin
        errors++; $display("FAIL zero_sym[%0d]: got %b required %b", i, got[i], exp_seq[i]);
      end
    end
    checks++;
    if (in_ready_cnt != 0) begin
      errors++; $display("FAIL zero_in_ready: got %0d cycles required 0", in_ready_cnt);
    end
    if (got.size() == 8) begin
      checks++;
      if (done_cyc != hs_cyc[7] + 5) begin
        errors++; $display("FAIL zero_done_time: got %0d required %0d", done_cyc, hs_cyc[7] + 5);
      end
    end
    tick();
  endtask

  task automatic test_starve();
    tx_bytes[0] = 8'hE4; tx_bytes[1] = 8'h1B; nbytes = 2;
    run_frame(1'b1, 8'd2, 0, 1, 10, 1'b0);
    checks++;
    if (got.size() != 16) begin
      errors++; $display("FAIL starve_count: got %0d symbols required 16", got.size());
    end
    for (int i = 8; i < 16 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_seq[i]) begin
        errors++; $display("FAIL starve_sym[%0d]: got %b required %b", i, got[i], exp_seq[i]);
      end
    end
    checks++;
    if (bubbles != 8) begin
      errors++; $display("FAIL starve_bubbles: got %0d required 8", bubbles);
    end
    if (got.size() == 16 && acc_cyc.size() == 2) begin
      checks++;
      if (hs_cyc[12] != acc_cyc[1] + 2) begin
        errors++; $display("FAIL starve_resume: got %0d required %0d", hs_cyc[12], acc_cyc[1] + 2);
      end
    end
    tick();
  endtask

  task automatic test_start_ignored();
    tx_bytes[0] = 8'hE4; tx_bytes[1] = 8'h1B; nbytes = 2;
    run_frame(1'b1, 8'd2, 0, 0, 0, 1'b1);
    checks++;
    if (got.size() != 16 || acc_cyc.size() != 2) begin
      errors++;
      $display("FAIL ignore_len: got %0d symbols %0d bytes required 16 2", got.size(), acc_cyc.size());
    end
    if (got.size() == 16) begin
      checks++;
      if (done_cyc != hs_cyc[15] + 5) begin
        errors++; $display("FAIL ignore_done_time: got %0d required %0d", done_cyc, hs_cyc[15] + 5);
      end
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL ignore_idle: got busy %b required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    nbytes = 0;
    run_frame(1'b1, 8'd0, 0, 0, 0, 1'b0);
    checks++;
    if (done_cyc < 0) begin
      errors++; $display("FAIL b2b_first_done: got none required a done pulse");
    end
    bus.start = 1'b1; bus.frame_len = 8'd1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.sym_valid, bus.sym_is_preamble, bus.sym_idx} !== 5'b11100) begin
      errors++;
      $display("FAIL b2b_first_sym: got %b required 11100",
               {bus.busy, bus.sym_valid, bus.sym_is_preamble, bus.sym_idx});
    end
    tx_bytes[0] = 8'h9C; nbytes = 1;
    run_frame(1'b0, 8'd1, 0, 0, 0, 1'b0);
    checks++;
    if (got.size() != 12) begin
      errors++; $display("FAIL b2b_count: got %0d symbols required 12", got.size());
    end
    if (got.size() == 12) begin
      checks++;
      if ({got[8], got[9], got[10], got[11]} !== {3'd0, 3'd3, 3'd1, 3'd2}) begin
        errors++;
        $display("FAIL b2b_payload: got %0d %0d %0d %0d required 0 3 1 2", got[8], got[9], got[10], got[11]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_payload();
    int bad;
    bad = 0;
    bus.start = 1'b1; bus.frame_len = 8'd2;
    tick();
    bus.start = 1'b0; bus.sym_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hE4;
    repeat (9) tick();
    bus.sym_ready = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.sym_valid, bus.sym_is_preamble} !== 3'b110) begin
      errors++;
      $display("FAIL midrst_setup: got %b required 110", {bus.busy, bus.sym_valid, bus.sym_is_preamble});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sym_idx, bus.sym_valid, bus.sym_is_preamble, bus.busy, bus.done, bus.in_ready} !== 7'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b required 0000000",
               {bus.sym_idx, bus.sym_valid, bus.sym_is_preamble, bus.busy, bus.done, bus.in_ready});
    end
    tick();
    tick();
    rst_n = 1'b1;
    bus.sym_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.sym_valid || bus.done || bus.busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midrst_quiet: got %0d active cycles required 0", bad);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_seq[i] = (i % 2 == 1) ? 3'b110 : 3'b100;
    exp_seq[8]  = 3'd0; exp_seq[9]  = 3'd1; exp_seq[10] = 3'd2; exp_seq[11] = 3'd3;
    exp_seq[12] = 3'd3; exp_seq[13] = 3'd2; exp_seq[14] = 3'd1; exp_seq[15] = 3'd0;
    bus.start = 1'b0; bus.frame_len = '0; bus.in_data = '0; bus.in_valid = 1'b0; bus.sym_ready = 1'b1;
    nbytes = 0;
    tick();
    tick();
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_starve();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_payload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
